dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory behind a valid/ready request and
// response handshake. Each access waits WAIT_CYCLES extra cycles before its
// response is presented, and the response is held until the core takes it.
// Optional build macro: DMEM_RSP_ERR_CHECK_EN enables access-fault checking
// (out-of-range word index, unsupported store strobe pattern). Without it,
// the word index wraps modulo DEPTH_WORDS and any strobe pattern is applied.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  wait_cnt_q;

    logic        lat_we_q;
    logic [29:0] lat_word_q;
    logic [31:0] lat_wdata_q;
    logic [3:0]  lat_wstrb_q;

    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic             op_we;
    logic [29:0]      op_word;
    logic [31:0]      op_wdata;
    logic [3:0]       op_wstrb;
    logic [IDX_W-1:0] op_idx;
    logic             op_fault;
    logic             mem_we;
    logic             unused_bits;

    // A request is taken only while the responder advertises ready.
    assign accept = req_valid_i & req_ready_o;

    // The access itself happens on the edge that enters RESP. With no wait
    // cycles that edge is the accept edge, so the live request inputs are
    // used; otherwise the copy latched at accept is used.
    always_comb begin
        op_we    = lat_we_q;
        op_word  = lat_word_q;
        op_wdata = lat_wdata_q;
        op_wstrb = lat_wstrb_q;
        if (state_q == IDLE) begin
            op_we    = req_we_i;
            op_word  = req_addr_i[31:2];
            op_wdata = req_wdata_i;
            op_wstrb = req_wstrb_i;
        end
    end

    assign op_idx = op_word[IDX_W-1:0];

`ifdef DMEM_RSP_ERR_CHECK_EN
    logic strobe_ok;

    // Stores may only use single bytes, aligned halfwords or the full word.
    always_comb begin
        strobe_ok = 1'b0;
        case (op_wstrb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: strobe_ok = 1'b1;
            default:                   strobe_ok = 1'b0;
        endcase
    end

    assign op_fault    = (op_word >= 30'(DEPTH_WORDS)) || (op_we && !strobe_ok);
    assign unused_bits = ^req_addr_i[1:0];
`else
    assign op_fault    = 1'b0;
    assign unused_bits = ^{req_addr_i[1:0], op_word[29:IDX_W]};
`endif

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the accept / wait / respond sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign mem_we     = enter_resp && op_we && !op_fault;

    // Outputs: ready only in IDLE outside reset, response only in RESP.
    always_comb begin
        req_ready_o = rst_ni && (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);
        rsp_rdata_o = 32'd0;
        rsp_err_o   = 1'b0;
        if (state_q == RESP) begin
            rsp_rdata_o = rsp_rdata_q;
            rsp_err_o   = rsp_err_q;
        end
    end

    // Request latch, wait counter and the held response word/flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q  <= 4'd0;
            lat_we_q    <= 1'b0;
            lat_word_q  <= 30'd0;
            lat_wdata_q <= 32'd0;
            lat_wstrb_q <= 4'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we_q    <= req_we_i;
                lat_word_q  <= req_addr_i[31:2];
                lat_wdata_q <= req_wdata_i;
                lat_wstrb_q <= req_wstrb_i;
                wait_cnt_q  <= WAIT_LOAD;
            end else if ((state_q == WAIT) && (wait_cnt_q != 4'd0)) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end
            if (enter_resp) begin
                rsp_err_q   <= op_fault;
                rsp_rdata_q <= (op_we || op_fault) ? 32'd0 : mem[op_idx];
            end
        end
    end

    // Storage array is never reset; stores update only strobed byte lanes.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (op_wstrb[b]) begin
                    mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
